// File: rtl/vga_line_fetch.sv
// vga_line_fetch: keeps the ping-pong VGA line RAM filled one line ahead of scan-out
module vga_line_fetch #(
  parameter int PIX_PER_LINE = 640,
  parameter int FIRST_LINE   = 30,
  parameter int LAST_LINE    = 509,
  parameter int ADDR_W       = 19
) (
  input  logic              i_clk_sys,
  input  logic              i_rst,
  input  logic              i_enable,
  input  logic              i_line_start,
  input  logic [9:0]        i_line_num,
  output logic              o_rd_req,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic              i_rd_ack,
  input  logic [15:0]       i_rd_data,
  output logic              o_ram_wen,
  output logic [10:0]       o_ram_waddr,
  output logic [15:0]       o_ram_wdata,
  output logic              o_disp_bank,
  output logic              o_busy,
  output logic              o_underrun,
  input  logic              i_err_clr
);
  typedef enum logic {IDLE, REQ} state_t;
  state_t            r_state;
  logic [9:0]        r_pix;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_tbank;
  logic              r_ram_wen;
  logic [10:0]       r_ram_waddr;
  logic [15:0]       r_ram_wdata;
  logic              r_disp_bank;
  logic              r_underrun;
  logic              w_in_win;
  logic              w_start;
  logic [9:0]        w_row;
  logic [ADDR_W-1:0] w_base;
  logic              w_ack;
  logic              w_last;
  logic              w_abort;
  assign w_in_win = (i_line_num >= 10'(FIRST_LINE - 1)) && (i_line_num <= 10'(LAST_LINE - 1));
  assign w_start  = i_line_start & i_enable & w_in_win;
  assign w_row    = i_line_num - 10'(FIRST_LINE - 1);
  // row*640 as two shifts so no multiplier is needed
  assign w_base   = (ADDR_W'(w_row) << 9) + (ADDR_W'(w_row) << 7);
  assign w_ack    = (r_state == REQ) & i_rd_ack;
  assign w_last   = w_ack & (r_pix == 10'(PIX_PER_LINE - 1));
  // a line start that finds the fetch unfinished kills it, unless the final ack lands the same cycle
  assign w_abort  = i_line_start & (r_state == REQ) & ~w_last;
  // fetch sequencer: latch target bank and row base on start, walk pixels on each accepted ack
  always_ff @(posedge i_clk_sys or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_pix     <= '0;
      r_rd_addr <= '0;
      r_tbank   <= 1'b0;
    end else if (w_start) begin
      r_state   <= REQ;
      r_pix     <= '0;
      r_rd_addr <= w_base;
      r_tbank   <= r_disp_bank;
    end else if (w_last || w_abort) begin
      r_state   <= IDLE;
    end else if (w_ack) begin
      r_pix     <= r_pix + 10'd1;
      r_rd_addr <= r_rd_addr + 1'b1;
    end
  end
  // line RAM write one cycle after each ack, bank flip per line, sticky underrun with set priority
  always_ff @(posedge i_clk_sys or posedge i_rst) begin
    if (i_rst) begin
      r_ram_wen   <= 1'b0;
      r_ram_waddr <= '0;
      r_ram_wdata <= '0;
      r_disp_bank <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_ram_wen   <= w_ack & ~w_abort;
      r_ram_waddr <= w_ack ? {r_tbank, r_pix} : r_ram_waddr;
      r_ram_wdata <= w_ack ? i_rd_data : r_ram_wdata;
      r_disp_bank <= i_line_start ? ~r_disp_bank : r_disp_bank;
      r_underrun  <= w_abort | (r_underrun & ~i_err_clr);
    end
  end
  assign o_rd_req    = (r_state == REQ);
  assign o_rd_addr   = r_rd_addr;
  assign o_ram_wen   = r_ram_wen;
  assign o_ram_waddr = r_ram_waddr;
  assign o_ram_wdata = r_ram_wdata;
  assign o_disp_bank = r_disp_bank;
  assign o_busy      = (r_state == REQ) | r_ram_wen;
  assign o_underrun  = r_underrun;
endmodule

// File: tb/tb_vga_line_fetch.sv
// tb_vga_line_fetch: directed vector table plus hand sequences for underrun, coincidence and reset
module tb_vga_line_fetch;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        line_start = 1'b0;
  logic [9:0]  line_num = '0;
  logic        rd_ack = 1'b0;
  logic        err_clr = 1'b0;
  logic        rd_req;
  logic [18:0] rd_addr;
  logic [15:0] rd_data;
  logic        ram_wen;
  logic [10:0] ram_waddr;
  logic [15:0] ram_wdata;
  logic        disp_bank;
  logic        busy;
  logic        underrun;
  int          checks = 0;
  int          failures = 0;
  logic        exp_disp = 1'b0;

  typedef struct {
    logic [9:0] ln;
    logic       en;
    int         per;
    logic       fetch;
    int         base;
    int         drop_at;
  } vec_t;
  vec_t tv[8];

  vga_line_fetch dut (
    .i_clk_sys(clk), .i_rst(rst), .i_enable(enable), .i_line_start(line_start),
    .i_line_num(line_num), .o_rd_req(rd_req), .o_rd_addr(rd_addr), .i_rd_ack(rd_ack),
    .i_rd_data(rd_data), .o_ram_wen(ram_wen), .o_ram_waddr(ram_waddr),
    .o_ram_wdata(ram_wdata), .o_disp_bank(disp_bank), .o_busy(busy),
    .o_underrun(underrun), .i_err_clr(err_clr)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] pix(input logic [18:0] a);
    return a[15:0] ^ {a[18:16], 13'h0A5A};
  endfunction

  assign rd_data = pix(rd_addr);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_line(input logic [9:0] ln);
    line_start = 1'b1;
    line_num = ln;
    tick();
    line_start = 1'b0;
    exp_disp = ~exp_disp;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rd_req"}, rd_req, 0);
    chk({tag, "_rd_addr"}, rd_addr, 0);
    chk({tag, "_ram_wen"}, ram_wen, 0);
    chk({tag, "_ram_waddr"}, ram_waddr, 0);
    chk({tag, "_ram_wdata"}, ram_wdata, 0);
    chk({tag, "_disp_bank"}, disp_bank, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_underrun"}, underrun, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic tgt;
    tv[0] = '{10'd29,  1'b1, 1, 1'b1, 0,      -1};
    tv[1] = '{10'd100, 1'b1, 3, 1'b1, 45440,  -1};
    tv[2] = '{10'd508, 1'b1, 1, 1'b1, 306560, -1};
    tv[3] = '{10'd509, 1'b1, 1, 1'b0, 0,      -1};
    tv[4] = '{10'd28,  1'b1, 1, 1'b0, 0,      -1};
    tv[5] = '{10'd50,  1'b0, 1, 1'b0, 0,      -1};
    tv[6] = '{10'd200, 1'b1, 1, 1'b1, 109440, 100};
    tv[7] = '{10'd30,  1'b1, 2, 1'b1, 640,    -1};
    repeat (3) @(negedge clk);
    chk_reset_outputs("init");
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      int   nacks;
      int   nw;
      logic took;
      logic exp_req;
      tgt = exp_disp;
      enable = tv[i].en;
      rd_ack = 1'b0;
      line_start = 1'b1;
      line_num = tv[i].ln;
      nacks = 0;
      nw = 0;
      took = 1'b0;
      for (int k = 0; k < tv[i].per * 640 + 6; k++) begin
        tick();
        if (k == 0) begin
          line_start = 1'b0;
          exp_disp = ~exp_disp;
        end
        rd_ack = ((k % tv[i].per) == tv[i].per - 1);
        if (k == tv[i].drop_at) enable = 1'b0;
        @(negedge clk);
        exp_req = tv[i].fetch && (nacks < 640);
        chk("rd_req", rd_req, exp_req);
        if (exp_req) chk("rd_addr", rd_addr, tv[i].base + nacks);
        chk("ram_wen", ram_wen, took);
        chk("busy", busy, exp_req | took);
        if (ram_wen) begin
          chk("ram_waddr", ram_waddr, {tgt, nw[9:0]});
          chk("ram_wdata", ram_wdata, pix(19'(tv[i].base + nw)));
          nw++;
        end
        took = exp_req && rd_ack;
        if (took) nacks++;
      end
      chk("vec_writes", nw, tv[i].fetch ? 640 : 0);
      chk("vec_disp_bank", disp_bank, exp_disp);
      chk("vec_underrun", underrun, 0);
    end
    enable = 1'b1;
    rd_ack = 1'b0;
    tgt = exp_disp;
    pulse_line(10'd40);
    repeat (100) tick();
    @(negedge clk);
    chk("ur_wait_req", rd_req, 1);
    chk("ur_wait_addr", rd_addr, 7040);
    chk("ur_wait_flag", underrun, 0);
    pulse_line(10'd41);
    @(negedge clk);
    chk("ur_flag", underrun, 1);
    chk("ur_new_req", rd_req, 1);
    chk("ur_new_addr", rd_addr, 7680);
    chk("ur_no_write", ram_wen, 0);
    chk("ur_disp_bank", disp_bank, exp_disp);
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
    @(negedge clk);
    chk("ur_wen", ram_wen, 1);
    chk("ur_waddr", ram_waddr, {~tgt, 10'd0});
    chk("ur_wdata", ram_wdata, pix(19'd7680));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    @(negedge clk);
    chk("ur_clr", underrun, 0);
    err_clr = 1'b1;
    pulse_line(10'd42);
    err_clr = 1'b0;
    @(negedge clk);
    chk("ur_set_wins", underrun, 1);
    chk("ur_addr42", rd_addr, 8320);
    pulse_line(10'd0);
    @(negedge clk);
    chk("ur_abort_idle", rd_req, 0);
    chk("ur_abort_flag", underrun, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    @(negedge clk);
    chk("ur_clr2", underrun, 0);
    chk("ur_busy", busy, 0);
    tgt = exp_disp;
    rd_ack = 1'b1;
    pulse_line(10'd60);
    repeat (639) tick();
    line_start = 1'b1;
    line_num = 10'd61;
    tick();
    line_start = 1'b0;
    exp_disp = ~exp_disp;
    @(negedge clk);
    chk("co_wen", ram_wen, 1);
    chk("co_waddr", ram_waddr, {tgt, 10'd639});
    chk("co_wdata", ram_wdata, pix(19'd20479));
    chk("co_underrun", underrun, 0);
    chk("co_new_req", rd_req, 1);
    chk("co_new_addr", rd_addr, 20480);
    chk("co_disp_bank", disp_bank, exp_disp);
    repeat (300) tick();
    @(negedge clk);
    chk("rs_mid_addr", rd_addr, 20780);
    chk("rs_mid_wen", ram_wen, 1);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("rs_now");
    exp_disp = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rs_hold_wen", ram_wen, 0);
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rs_after_req", rd_req, 0);
      chk("rs_after_wen", ram_wen, 0);
    end
    rd_ack = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
